// File: rtl/jtag_axi_pkg.sv
// Shared types and constants for the JTAG-to-AXI bridge: TAP states, instruction
// codes, streaming beat layouts and DR width helpers.
package jtag_axi_pkg;

  typedef enum logic [3:0] {
    TEST_LOGIC_RESET = 4'h0,
    RUN_TEST_IDLE    = 4'h1,
    SELECT_DR_SCAN   = 4'h2,
    CAPTURE_DR       = 4'h3,
    SHIFT_DR         = 4'h4,
    EXIT1_DR         = 4'h5,
    PAUSE_DR         = 4'h6,
    EXIT2_DR         = 4'h7,
    UPDATE_DR        = 4'h8,
    SELECT_IR_SCAN   = 4'h9,
    CAPTURE_IR       = 4'hA,
    SHIFT_IR         = 4'hB,
    EXIT1_IR         = 4'hC,
    PAUSE_IR         = 4'hD,
    EXIT2_IR         = 4'hE,
    UPDATE_IR        = 4'hF
  } tap_ctrl_fsm_t;

  typedef enum logic [3:0] {
    IDCODE          = 4'h1,
    IC_RESET        = 4'h2,
    ADDR_AXI_REG    = 4'h3,
    WSTRB_AXI_REG   = 4'h4,
    DATA_W_AXI_REG  = 4'h5,
    STREAM_CTRL_REG = 4'h6,
    DATA_R_AXI_REG  = 4'h7,
    BYPASS          = 4'hF
  } ir_decoding_t;

  localparam int DR_IDCODE_W      = 32;
  localparam int DR_STREAM_CTRL_W = 8;

  // Bit positions inside STREAM_CTRL_REG.
  localparam int CTRL_OVF      = 0;
  localparam int CTRL_AUTO_INC = 1;
  localparam int CTRL_RD_GO    = 2;
  localparam int CTRL_CLR      = 3;

  // Beat layouts at the default bus widths; the engine mirrors them at its own widths.
  localparam int AXI_ADDR_W = 32;
  localparam int AXI_DATA_W = 32;

  typedef struct packed {
    logic [AXI_ADDR_W-1:0]   addr;
    logic [AXI_DATA_W/8-1:0] strb;
    logic [AXI_DATA_W-1:0]   data;
  } s_jtag_wbeat_t;

  typedef struct packed {
    logic [AXI_DATA_W-1:0] data;
    logic                  err;
  } s_jtag_rbeat_t;

  function automatic int sr_width(input int aw, input int dw, input int icw);
    int w;
    w = DR_IDCODE_W;
    if (aw > w) w = aw;
    if (dw + 2 > w) w = dw + 2;
    if (icw > w) w = icw;
    if (DR_STREAM_CTRL_W > w) w = DR_STREAM_CTRL_W;
    return w;
  endfunction

  function automatic bit is_pow2(input int v);
    return (v > 0) && ((v & (v - 1)) == 0);
  endfunction

endpackage

// File: rtl/jtag_axi_sync_fifo.sv
// First-word-fall-through synchronous FIFO; push is accepted when full if a pop
// happens in the same cycle, and clr overrides both.
module jtag_axi_sync_fifo
  import jtag_axi_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push_i,
  input  logic                   pop_i,
  input  logic                   clr_i,
  input  logic [WIDTH-1:0]       wdata_i,
  output logic [WIDTH-1:0]       rdata_o,
  output logic                   full_o,
  output logic                   empty_o,
  output logic [$clog2(DEPTH):0] count_o
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic             do_push, do_pop;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == (AW+1)'(DEPTH));
  assign count_o = count_q;
  assign rdata_o = mem_q[rd_ptr_q];

  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);

  always_comb begin
    wr_ptr_d = wr_ptr_q + AW'(do_push);
    rd_ptr_d = rd_ptr_q + AW'(do_pop);
    count_d  = count_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
    if (clr_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset; a cleared FIFO never exposes stale entries.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata_i;
  end

endmodule

// File: rtl/jtag_axi_dr_stream.sv
// JTAG data-register engine with buffered AXI write/read beat streams: DR updates
// queue write beats, DR captures drain returned read beats.
module jtag_axi_dr_stream
  import jtag_axi_pkg::*;
#(
  parameter logic [31:0] IDCODE_VAL   = 32'hBADC0FFE,
  parameter int          IC_RST_WIDTH = 4,
  parameter int          ADDR_WIDTH   = 32,
  parameter int          DATA_WIDTH   = 32,
  parameter int          WFIFO_DEPTH  = 8,
  parameter int          RFIFO_DEPTH  = 8
) (
  input  logic                    tck,
  input  logic                    trstn,
  input  logic                    tdi,
  output logic                    tdo,
  input  tap_ctrl_fsm_t           tap_state,
  input  ir_decoding_t            ir_dec,
  output logic [IC_RST_WIDTH-1:0] ic_rst,
  output logic                    wb_valid_o,
  input  logic                    wb_ready_i,
  output logic [ADDR_WIDTH-1:0]   wb_addr_o,
  output logic [DATA_WIDTH-1:0]   wb_data_o,
  output logic [DATA_WIDTH/8-1:0] wb_strb_o,
  input  logic                    rb_valid_i,
  output logic                    rb_ready_o,
  input  logic [DATA_WIDTH-1:0]   rb_data_i,
  input  logic                    rb_err_i,
  output logic                    rd_req_o
);

  localparam int STRB_W = DATA_WIDTH / 8;
  localparam int SR_W   = sr_width(ADDR_WIDTH, DATA_WIDTH, IC_RST_WIDTH);
  localparam logic [ADDR_WIDTH-1:0] ADDR_STEP = ADDR_WIDTH'(STRB_W);

  if (!is_pow2(DATA_WIDTH) || DATA_WIDTH < 8) begin : g_bad_data_width
    $error("DATA_WIDTH must be a power of two and at least 8");
  end
  if (!is_pow2(WFIFO_DEPTH) || WFIFO_DEPTH < 2) begin : g_bad_wfifo_depth
    $error("WFIFO_DEPTH must be a power of two and at least 2");
  end
  if (!is_pow2(RFIFO_DEPTH) || RFIFO_DEPTH < 2) begin : g_bad_rfifo_depth
    $error("RFIFO_DEPTH must be a power of two and at least 2");
  end

  typedef struct packed {
    logic [ADDR_WIDTH-1:0] addr;
    logic [STRB_W-1:0]     strb;
    logic [DATA_WIDTH-1:0] data;
  } wbeat_t;

  typedef struct packed {
    logic [DATA_WIDTH-1:0] data;
    logic                  err;
  } rbeat_t;

  logic [SR_W-1:0]         sr_q, sr_d, cap_val;
  logic                    tdo_q;
  logic [IC_RST_WIDTH-1:0] ic_rst_q, ic_rst_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [STRB_W-1:0]       strb_q, strb_d;
  logic                    auto_inc_q, auto_inc_d;
  logic                    ovf_q, ovf_d;
  logic                    rerr_q, rerr_d;
  logic                    rd_req_q, rd_req_d;
  int                      dr_len;

  logic   capture, shift, update, clr;
  logic   wpush, wpop, wfull, wempty;
  logic   rpush, rpop, rfull, rempty;
  wbeat_t wnew, whead;
  rbeat_t rnew, rhead;
  logic [$clog2(WFIFO_DEPTH):0] wcount;
  logic [$clog2(RFIFO_DEPTH):0] rcount;
  logic   unused_counts;

  assign capture = (tap_state == CAPTURE_DR);
  assign shift   = (tap_state == SHIFT_DR);
  assign update  = (tap_state == UPDATE_DR);
  assign clr     = update && (ir_dec == STREAM_CTRL_REG) && sr_q[CTRL_CLR];

  assign wpop  = !wempty && wb_ready_i;
  assign wpush = update && (ir_dec == DATA_W_AXI_REG) && (!wfull || wpop);
  assign wnew  = {addr_q, strb_q, sr_q[DATA_WIDTH:1]};
  assign rpush = rb_valid_i && !rfull;
  assign rpop  = capture && (ir_dec == DATA_R_AXI_REG) && !rempty;
  assign rnew  = {rb_data_i, rb_err_i};

  always_comb begin
    case (ir_dec)
      IDCODE:          dr_len = DR_IDCODE_W;
      IC_RESET:        dr_len = IC_RST_WIDTH;
      ADDR_AXI_REG:    dr_len = ADDR_WIDTH;
      WSTRB_AXI_REG:   dr_len = STRB_W;
      STREAM_CTRL_REG: dr_len = DR_STREAM_CTRL_W;
      DATA_W_AXI_REG:  dr_len = DATA_WIDTH + 1;
      DATA_R_AXI_REG:  dr_len = DATA_WIDTH + 2;
      default:         dr_len = 1;
    endcase
  end

  always_comb begin
    cap_val = '0;
    case (ir_dec)
      IDCODE:          cap_val[31:0] = IDCODE_VAL;
      IC_RESET:        cap_val[IC_RST_WIDTH-1:0] = ic_rst_q;
      ADDR_AXI_REG:    cap_val[ADDR_WIDTH-1:0] = addr_q;
      WSTRB_AXI_REG:   cap_val[STRB_W-1:0] = strb_q;
      STREAM_CTRL_REG: cap_val[1:0] = {auto_inc_q, ovf_q};
      DATA_W_AXI_REG:  cap_val[0] = wfull;
      DATA_R_AXI_REG:  if (!rempty) cap_val[DATA_WIDTH+1:0] = {rhead.data, rhead.err, 1'b1};
      default:         cap_val = '0;
    endcase
  end

  // Only the low dr_len bits take part in a shift; tdi enters at the top of that window.
  always_comb begin
    sr_d = sr_q;
    if (capture) begin
      sr_d = cap_val;
    end else if (shift) begin
      for (int i = 0; i < SR_W - 1; i++) begin
        if (i == dr_len - 1)     sr_d[i] = tdi;
        else if (i < dr_len - 1) sr_d[i] = sr_q[i+1];
      end
      if (dr_len == SR_W) sr_d[SR_W-1] = tdi;
    end
  end

  always_comb begin
    ic_rst_d   = ic_rst_q;
    addr_d     = addr_q;
    strb_d     = strb_q;
    auto_inc_d = auto_inc_q;
    ovf_d      = ovf_q;
    rerr_d     = rerr_q | (rpush && rb_err_i);
    rd_req_d   = 1'b0;
    if (update) begin
      case (ir_dec)
        IC_RESET:        ic_rst_d = sr_q[IC_RST_WIDTH-1:0];
        ADDR_AXI_REG:    addr_d = sr_q[ADDR_WIDTH-1:0];
        WSTRB_AXI_REG:   strb_d = sr_q[STRB_W-1:0];
        STREAM_CTRL_REG: begin
          auto_inc_d = sr_q[CTRL_AUTO_INC];
          rd_req_d   = sr_q[CTRL_RD_GO];
        end
        DATA_W_AXI_REG: begin
          if (!wpush)          ovf_d  = 1'b1;
          else if (auto_inc_q) addr_d = addr_q + ADDR_STEP;
        end
        DATA_R_AXI_REG: begin
          if (auto_inc_q) begin
            addr_d   = addr_q + ADDR_STEP;
            rd_req_d = 1'b1;
          end
        end
        default: ;
      endcase
    end
    if (clr) begin
      ovf_d  = 1'b0;
      rerr_d = 1'b0;
    end
  end

  always_ff @(posedge tck or negedge trstn) begin
    if (!trstn) begin
      sr_q       <= '0;
      ic_rst_q   <= '0;
      addr_q     <= '0;
      strb_q     <= '1;
      auto_inc_q <= 1'b0;
      ovf_q      <= 1'b0;
      rerr_q     <= 1'b0;
      rd_req_q   <= 1'b0;
    end else begin
      sr_q       <= sr_d;
      ic_rst_q   <= ic_rst_d;
      addr_q     <= addr_d;
      strb_q     <= strb_d;
      auto_inc_q <= auto_inc_d;
      ovf_q      <= ovf_d;
      rerr_q     <= rerr_d;
      rd_req_q   <= rd_req_d;
    end
  end

  // Negedge copy keeps tdo stable across the posedge at which the TAP samples it.
  always_ff @(negedge tck or negedge trstn) begin
    if (!trstn) tdo_q <= 1'b0;
    else        tdo_q <= (shift || tap_state == EXIT1_DR) ? sr_q[0] : 1'b0;
  end

  jtag_axi_sync_fifo #(.WIDTH($bits(wbeat_t)), .DEPTH(WFIFO_DEPTH)) u_wfifo (
    .clk     (tck),
    .rst_n   (trstn),
    .push_i  (wpush),
    .pop_i   (wpop),
    .clr_i   (clr),
    .wdata_i (wnew),
    .rdata_o (whead),
    .full_o  (wfull),
    .empty_o (wempty),
    .count_o (wcount)
  );

  jtag_axi_sync_fifo #(.WIDTH($bits(rbeat_t)), .DEPTH(RFIFO_DEPTH)) u_rfifo (
    .clk     (tck),
    .rst_n   (trstn),
    .push_i  (rpush),
    .pop_i   (rpop),
    .clr_i   (clr),
    .wdata_i (rnew),
    .rdata_o (rhead),
    .full_o  (rfull),
    .empty_o (rempty),
    .count_o (rcount)
  );

  assign unused_counts = ^{wcount, rcount};

  assign tdo        = tdo_q;
  assign ic_rst     = ic_rst_q;
  assign wb_valid_o = !wempty;
  assign wb_addr_o  = whead.addr;
  assign wb_strb_o  = whead.strb;
  assign wb_data_o  = whead.data;
  assign rb_ready_o = !rfull;
  assign rd_req_o   = rd_req_q;

endmodule

// File: tb/tb_jtag_axi_dr_stream.sv
// Directed bench for jtag_axi_dr_stream at default parameters: IDCODE, burst write,
// overflow, read stream, simultaneous push/pop, clear, wrap and async reset.
module tb_jtag_axi_dr_stream;
  import jtag_axi_pkg::*;

  logic          tck, trstn, tdi, tdo;
  tap_ctrl_fsm_t tap_state;
  ir_decoding_t  ir_dec;
  logic [3:0]    ic_rst;
  logic          wb_valid_o, wb_ready_i;
  logic [31:0]   wb_addr_o, wb_data_o;
  logic [3:0]    wb_strb_o;
  logic          rb_valid_i, rb_ready_o, rb_err_i, rd_req_o;
  logic [31:0]   rb_data_i;

  int n_assert = 0;
  int n_fail   = 0;

  jtag_axi_dr_stream dut (
    .tck(tck), .trstn(trstn), .tdi(tdi), .tdo(tdo),
    .tap_state(tap_state), .ir_dec(ir_dec), .ic_rst(ic_rst),
    .wb_valid_o(wb_valid_o), .wb_ready_i(wb_ready_i), .wb_addr_o(wb_addr_o),
    .wb_data_o(wb_data_o), .wb_strb_o(wb_strb_o),
    .rb_valid_i(rb_valid_i), .rb_ready_o(rb_ready_o), .rb_data_i(rb_data_i),
    .rb_err_i(rb_err_i), .rd_req_o(rd_req_o)
  );

  initial tck = 1'b0;
  always #5 tck = ~tck;

  initial begin
    #1000000;
    $display("FAIL timeout: observed no end of test, expected $finish");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Full DR scan; inputs change 1 time unit after posedge, tdo sampled 1 after negedge.
  task automatic dr_scan(input ir_decoding_t ir, input int len, input logic [63:0] din,
                         input bit do_update, input bit pop_at_update, output logic [63:0] dout);
    ir_dec    = ir;
    tap_state = CAPTURE_DR;
    @(posedge tck); #1;
    tap_state = SHIFT_DR;
    dout = '0;
    for (int i = 0; i < len; i++) begin
      tdi = din[i];
      @(negedge tck); #1;
      dout[i] = tdo;
      @(posedge tck); #1;
    end
    tdi = 1'b0;
    tap_state = EXIT1_DR;
    @(posedge tck); #1;
    if (do_update) begin
      tap_state = UPDATE_DR;
      if (pop_at_update) wb_ready_i = 1'b1;
      @(posedge tck); #1;
      wb_ready_i = 1'b0;
    end
    tap_state = RUN_TEST_IDLE;
  endtask

  task automatic wr_dr(input ir_decoding_t ir, input int len, input logic [63:0] din);
    logic [63:0] unused_out;
    dr_scan(ir, len, din, 1'b1, 1'b0, unused_out);
  endtask

  task automatic rd_dr(input ir_decoding_t ir, input int len, output logic [63:0] dout);
    dr_scan(ir, len, 64'd0, 1'b0, 1'b0, dout);
  endtask

  task automatic push_w(input logic [31:0] data);
    wr_dr(DATA_W_AXI_REG, 33, {31'd0, data, 1'b0});
  endtask

  task automatic drain_check(input string tag, input logic [31:0] ea, input logic [31:0] ed,
                             input logic [3:0] es);
    check({tag, " valid"}, 64'(wb_valid_o), 64'd1);
    check({tag, " addr"}, 64'(wb_addr_o), 64'(ea));
    check({tag, " data"}, 64'(wb_data_o), 64'(ed));
    check({tag, " strb"}, 64'(wb_strb_o), 64'(es));
    wb_ready_i = 1'b1;
    @(posedge tck); #1;
    wb_ready_i = 1'b0;
  endtask

  task automatic inject_r(input logic [31:0] data, input logic err);
    rb_valid_i = 1'b1;
    rb_data_i  = data;
    rb_err_i   = err;
    @(posedge tck); #1;
    rb_valid_i = 1'b0;
    rb_data_i  = '0;
    rb_err_i   = 1'b0;
  endtask

  logic [63:0] rd;
  logic [31:0] idc;

  initial begin
    trstn = 1'b0; tdi = 1'b0; tap_state = TEST_LOGIC_RESET; ir_dec = BYPASS;
    wb_ready_i = 1'b0; rb_valid_i = 1'b0; rb_data_i = '0; rb_err_i = 1'b0;
    #12;
    check("reset tdo", 64'(tdo), 64'd0);
    check("reset ic_rst", 64'(ic_rst), 64'd0);
    check("reset wb_valid", 64'(wb_valid_o), 64'd0);
    check("reset rb_ready", 64'(rb_ready_o), 64'd1);
    check("reset rd_req", 64'(rd_req_o), 64'd0);
    trstn = 1'b1;
    tap_state = RUN_TEST_IDLE;
    @(posedge tck); #1;

    // IDCODE, checking each bit just after negedge and again just after the next posedge
    idc = 32'hBADC0FFE;
    ir_dec = IDCODE; tap_state = CAPTURE_DR;
    @(posedge tck); #1;
    tap_state = SHIFT_DR;
    for (int i = 0; i < 32; i++) begin
      @(negedge tck); #1;
      check($sformatf("idcode bit%0d", i), 64'(tdo), 64'(idc[i]));
      @(posedge tck); #1;
      check($sformatf("idcode hold bit%0d", i), 64'(tdo), 64'(idc[i]));
    end
    tap_state = EXIT1_DR; @(posedge tck); #1;
    tap_state = RUN_TEST_IDLE;

    rd_dr(WSTRB_AXI_REG, 4, rd);
    check("wstrb reset capture", rd, 64'hF);

    // Burst write with auto-increment
    wr_dr(STREAM_CTRL_REG, 8, 64'h02);
    wr_dr(ADDR_AXI_REG, 32, 64'h1000);
    push_w(32'h11111111);
    check("burst first beat valid", 64'(wb_valid_o), 64'd1);
    check("burst first beat addr", 64'(wb_addr_o), 64'h1000);
    push_w(32'h22222222);
    push_w(32'h33333333);
    rd_dr(ADDR_AXI_REG, 32, rd);
    check("burst addr after 3", rd, 64'h100C);
    rd_dr(DATA_W_AXI_REG, 33, rd);
    check("burst wfull capture", rd, 64'h0);
    drain_check("burst beat0", 32'h1000, 32'h11111111, 4'hF);
    drain_check("burst beat1", 32'h1004, 32'h22222222, 4'hF);
    drain_check("burst beat2", 32'h1008, 32'h33333333, 4'hF);
    check("burst drained", 64'(wb_valid_o), 64'd0);

    // Overflow: 9 pushes into an 8-deep FIFO
    wr_dr(STREAM_CTRL_REG, 8, 64'h00);
    wr_dr(ADDR_AXI_REG, 32, 64'h2000);
    for (int i = 0; i < 9; i++) push_w(32'hC0DE0000 + 32'(i));
    rd_dr(STREAM_CTRL_REG, 8, rd);
    check("ovf ctrl capture", rd, 64'h01);
    rd_dr(DATA_W_AXI_REG, 33, rd);
    check("ovf wfull capture", rd, 64'h1);
    for (int i = 0; i < 8; i++)
      drain_check($sformatf("ovf beat%0d", i), 32'h2000, 32'hC0DE0000 + 32'(i), 4'hF);
    check("ovf 9th dropped", 64'(wb_valid_o), 64'd0);
    wr_dr(STREAM_CTRL_REG, 8, 64'h08);
    rd_dr(STREAM_CTRL_REG, 8, rd);
    check("clr clears ovf", rd, 64'h00);

    // Full FIFO: push coinciding with a pop is accepted, no overflow
    for (int i = 0; i < 8; i++) push_w(32'h50 + 32'(i));
    dr_scan(DATA_W_AXI_REG, 33, {31'd0, 32'h58, 1'b0}, 1'b1, 1'b1, rd);
    rd_dr(DATA_W_AXI_REG, 33, rd);
    check("simul still full", rd, 64'h1);
    rd_dr(STREAM_CTRL_REG, 8, rd);
    check("simul no ovf", rd, 64'h00);
    for (int i = 0; i < 8; i++)
      drain_check($sformatf("simul beat%0d", i), 32'h2000, 32'h51 + 32'(i), 4'hF);
    check("simul drained", 64'(wb_valid_o), 64'd0);

    // Clear flushes both FIFOs
    push_w(32'h60);
    push_w(32'h61);
    inject_r(32'h77, 1'b0);
    wr_dr(STREAM_CTRL_REG, 8, 64'h08);
    check("clr wfifo empty", 64'(wb_valid_o), 64'd0);
    rd_dr(DATA_R_AXI_REG, 34, rd);
    check("clr rfifo empty", rd, 64'h0);

    // Read stream
    inject_r(32'hA5A5A5A5, 1'b0);
    inject_r(32'hDEADBEEF, 1'b1);
    rd_dr(DATA_R_AXI_REG, 34, rd);
    check("rd beat0", rd, 64'({32'hA5A5A5A5, 2'b01}));
    rd_dr(DATA_R_AXI_REG, 34, rd);
    check("rd beat1", rd, 64'({32'hDEADBEEF, 2'b11}));
    rd_dr(DATA_R_AXI_REG, 34, rd);
    check("rd empty", rd, 64'h0);

    // Read requests
    wr_dr(ADDR_AXI_REG, 32, 64'h3000);
    wr_dr(STREAM_CTRL_REG, 8, 64'h06);
    check("rd_go pulse", 64'(rd_req_o), 64'd1);
    @(posedge tck); #1;
    check("rd_go pulse end", 64'(rd_req_o), 64'd0);
    wr_dr(DATA_R_AXI_REG, 34, 64'h0);
    check("data_r update pulse", 64'(rd_req_o), 64'd1);
    rd_dr(ADDR_AXI_REG, 32, rd);
    check("data_r addr inc", rd, 64'h3004);

    // Address wrap with custom strobes
    wr_dr(WSTRB_AXI_REG, 4, 64'h5);
    wr_dr(ADDR_AXI_REG, 32, 64'hFFFFFFFC);
    push_w(32'h12345678);
    rd_dr(ADDR_AXI_REG, 32, rd);
    check("addr wrap", rd, 64'h0);
    drain_check("wrap beat", 32'hFFFFFFFC, 32'h12345678, 4'h5);

    // Read FIFO full deasserts ready
    for (int i = 0; i < 8; i++) inject_r(32'h100 + 32'(i), 1'b0);
    check("rfifo full ready", 64'(rb_ready_o), 64'd0);

    wr_dr(IC_RESET, 4, 64'hF);
    check("ic_rst load", 64'(ic_rst), 64'hF);
    rd_dr(IC_RESET, 4, rd);
    check("ic_rst capture", rd, 64'hF);

    // Asynchronous reset mid-shift with both FIFOs occupied
    for (int i = 0; i < 4; i++) push_w(32'hAA00 + 32'(i));
    ir_dec = IDCODE; tap_state = CAPTURE_DR;
    @(posedge tck); #1;
    tap_state = SHIFT_DR;
    @(negedge tck); #1;
    @(posedge tck); #1;
    @(negedge tck); #1;
    check("pre-reset tdo", 64'(tdo), 64'd1);
    trstn = 1'b0;
    #1;
    check("arst tdo", 64'(tdo), 64'd0);
    check("arst ic_rst", 64'(ic_rst), 64'd0);
    check("arst wb_valid", 64'(wb_valid_o), 64'd0);
    check("arst rb_ready", 64'(rb_ready_o), 64'd1);
    check("arst rd_req", 64'(rd_req_o), 64'd0);
    #20;
    tap_state = RUN_TEST_IDLE;
    trstn = 1'b1;
    @(posedge tck); #1;
    rd_dr(ADDR_AXI_REG, 32, rd);
    check("post-reset addr", rd, 64'h0);
    rd_dr(WSTRB_AXI_REG, 4, rd);
    check("post-reset strb", rd, 64'hF);
    rd_dr(STREAM_CTRL_REG, 8, rd);
    check("post-reset ctrl", rd, 64'h0);
    rd_dr(DATA_R_AXI_REG, 34, rd);
    check("post-reset rfifo", rd, 64'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/jtag_axi_dr_stream.md
# jtag_axi_dr_stream

Parametrised JTAG data-register engine for the JTAG-to-AXI bridge. It supports configurable address and data widths and adds streaming write and read paths. DR updates push `{addr, wstrb, data}` beats into a write FIFO, with optional address auto-increment. DR captures pop read beats from a read FIFO. It sits between the TAP controller (`tap_state`, `ir_dec`) and the AXI master, replacing single-shot register transfers with buffered bursts.

## Interface
Parameters:
- `IDCODE_VAL`, 32'hBADC0FFE, value captured by IDCODE.
- `IC_RST_WIDTH`, 4, width of the reset-selection register.
- `ADDR_WIDTH`, 32, AXI address width.
- `DATA_WIDTH`, 32, AXI data width; must be a power of two and ≥ 8.
- `WFIFO_DEPTH`, 8, write-beat FIFO entries; must be a power of two and ≥ 2.
- `RFIFO_DEPTH`, 8, read-beat FIFO entries; must be a power of two and ≥ 2.

Ports:
- `tck`  in  1  JTAG clock, the only clock.
- `trstn`  in  1  reset, asynchronous, active-low.
- `tdi`  in  1  serial data in.
- `tdo`  out  1  serial data out; changes only on negedge `tck`.
- `tap_state`  in  `tap_ctrl_fsm_t`  current TAP state.
- `ir_dec`  in  `ir_decoding_t`  decoded instruction.
- `ic_rst`  out  `IC_RST_WIDTH`  reset-selection register.
- `wb_valid_o`  out  1  write FIFO not empty.
- `wb_ready_i`  in  1  AXI side accepts the head beat.
- `wb_addr_o`  out  `ADDR_WIDTH`  head beat address.
- `wb_data_o`  out  `DATA_WIDTH`  head beat data.
- `wb_strb_o`  out  `DATA_WIDTH/8`  head beat strobes.
- `rb_valid_i`  in  1  AXI side offers a read beat.
- `rb_ready_o`  out  1  read FIFO not full.
- `rb_data_i`  in  `DATA_WIDTH`  read beat data.
- `rb_err_i`  in  1  read beat response error.
- `rd_req_o`  out  1  one-`tck` pulse requesting a read at `addr_ff`.

## Operation
- Shared shift register `sr_ff` has width `SR_W = max(ADDR_WIDTH, DATA_WIDTH+2, 32, IC_RST_WIDTH, 8)`.
- Each DR shifts LSB-first, `{tdi, sr[W-1:1]}`, over its own width W.
- `tdo = sr_n_ff[0]` (negedge copy) in SHIFT_DR and EXIT1_DR of a selected DR; 0 otherwise.
- BYPASS: 1 bit, captures 0.
- IDCODE: 32 bits, captures `IDCODE_VAL`.
- IC_RESET: `IC_RST_WIDTH` bits. Captures current `ic_rst`; UPDATE_DR loads it.
- ADDR_AXI_REG: `ADDR_WIDTH` bits. Captures `addr_ff`; UPDATE_DR loads it.
- WSTRB_AXI_REG: `DATA_WIDTH/8` bits; same capture/update rule on `strb_ff`. Reset value is all ones.
- STREAM_CTRL_REG: 8 bits, `{4'b0, clr, rd_go, auto_inc, ovf}`.
  - Capture: `{4'b0, 0, 0, auto_inc_ff, ovf_ff}`.
  - UPDATE_DR: loads `auto_inc`.
  - `clr=1` flushes both FIFOs and clears `ovf_ff`, `rerr_ff`.
  - `rd_go=1` pulses `rd_req_o`.
- DATA_W_AXI_REG: `DATA_WIDTH+1` bits.
  - Capture: `{DATA_WIDTH'0, wfull}`.
  - UPDATE_DR: if the FIFO is not full, pushes `{addr_ff, strb_ff, sr[DATA_WIDTH:1]}`. If full, drops the beat and sets sticky `ovf_ff`.
  - After a successful push with `auto_inc_ff`, `addr_ff += DATA_WIDTH/8`. Wraps modulo 2^`ADDR_WIDTH`.
- DATA_R_AXI_REG: `DATA_WIDTH+2` bits, `{data, err, valid}`.
  - CAPTURE_DR with a non-empty read FIFO: loads the head and pops it; `valid=1`.
  - CAPTURE_DR with an empty read FIFO: loads 0; no pop.
  - UPDATE_DR: if `auto_inc_ff`, increments `addr_ff` and pulses `rd_req_o`.
- The write FIFO pops on `wb_valid_o && wb_ready_i`. The read FIFO pushes on `rb_valid_i && rb_ready_o`.
- A push and a pop in the same cycle on one FIFO both take effect; count is unchanged. This also holds when the FIFO is full.
- A `clr` in the same cycle as a push or pop wins: the FIFO ends empty.

## Timing
- All state is on posedge `tck`. The `sr_n_ff` copy is on negedge, so `tdo` is valid half a cycle after each shift.
- A beat pushed by UPDATE_DR appears on `wb_*` the next posedge: 1-cycle latency.
- `rd_req_o` is asserted the cycle after UPDATE_DR, for exactly 1 cycle.
- Reset values:
  - `tdo=0`, `ic_rst=0`, `wb_valid_o=0`, `rb_ready_o=1`, `rd_req_o=0`.
  - `addr_ff=0`, `strb_ff='1`, `auto_inc=0`, `ovf=0`.
  - FIFOs empty, `sr_ff=0`.
- Reset mid-shift or with FIFOs occupied discards all contents immediately (asynchronous).

## Structure
- `jtag_axi_pkg` gains:
  - `ir_decoding_t` codes `STREAM_CTRL_REG` and `DATA_R_AXI_REG`.
  - `s_jtag_wbeat_t {addr, strb, data}`.
  - `s_jtag_rbeat_t {data, err}`.
  - Localparam `DR_STREAM_CTRL_W = 8`.
- Sub-module `jtag_axi_sync_fifo`: parameters `WIDTH`, `DEPTH`; inputs push/pop/clr; outputs full/empty/count. Instantiated twice.
- Elaboration errors for a non-power-of-two `DATA_WIDTH` or FIFO depth.

## Test plan
- IDCODE: IR=IDCODE, shift 32 bits -> `tdo` serialises 0xBADC0FFE LSB first, each bit changing on negedge.
- Burst write: `auto_inc=1`, addr 0x1000, 3 DATA_W updates with `wb_ready_i=0` -> 3 beats queued at 0x1000/0x1004/0x1008; `addr_ff=0x100C`.
- Overflow: `WFIFO_DEPTH=8`, 9 pushes with `wb_ready_i=0` -> 9th dropped; CTRL capture shows `ovf=1`; the 8 queued beats drain in order once ready.
- Read stream: inject 2 beats (0xA5A5A5A5 with err=0, then 0xDEADBEEF with err=1) -> two DATA_R captures shift out `{data, err, valid=1}` for each; a third capture returns all zeros.
- Simultaneous: full write FIFO, UPDATE_DR push in the same cycle as a pop -> count stays 8, no overflow; then `clr` -> FIFOs empty, `ovf=0`.
- Reset: assert `trstn` mid SHIFT_DR with FIFOs half full -> every output returns to its reset value asynchronously.
